// File: rtl/demux_sel_seq_pkg.sv
// Shared encodings for the select sequencer and the downstream 1-to-4 demux.
package demux_sel_seq_pkg;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StRun  = 2'd1,
        StDone = 2'd2
    } state_e;

    localparam logic [1:0] SEL0 = 2'b00;
    localparam logic [1:0] SEL1 = 2'b01;
    localparam logic [1:0] SEL2 = 2'b10;
    localparam logic [1:0] SEL3 = 2'b11;

    localparam int unsigned CntW = 16;

    // Output-enable pattern the downstream demux derives from a select code.
    function automatic logic [3:0] sel_onehot(input logic [1:0] sel);
        unique case (sel)
            SEL0:    return 4'b0001;
            SEL1:    return 4'b0010;
            SEL2:    return 4'b0100;
            default: return 4'b1000;
        endcase
    endfunction

endpackage

// File: rtl/dwell_cnt.sv
// Dwell counter: counts enabled cycles and flags the last cycle of a DWELL-long period.
module dwell_cnt
    import demux_sel_seq_pkg::*;
#(
    parameter int unsigned DWELL = 100
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic tc
);

    localparam logic [CntW-1:0] Last = CntW'(DWELL - 1);

    logic [CntW-1:0] cnt_q, cnt_d;

    assign tc = en && (cnt_q == Last);

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = tc ? '0 : cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/demux_sel_seq.sv
// Select sequencer: sweeps a 1-to-4 demux select through 00..11, holding each code DWELL cycles.
module demux_sel_seq
    import demux_sel_seq_pkg::*;
#(
    parameter int unsigned DWELL = 100,
    parameter int unsigned DW    = 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          cont,
    input  logic          abort,
    input  logic [DW-1:0] din,
    output logic [DW-1:0] dout,
    output logic [1:0]    sel,
    output logic          busy,
    output logic          done
);

    state_e        state_q, state_d;
    logic [1:0]    sel_q, sel_d;
    logic [DW-1:0] dout_q, dout_d;
    logic          cont_q, cont_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          cnt_clr, cnt_en, cnt_tc;

    // Counter only runs in RUN; any other state (or an abort) parks it at zero.
    assign cnt_en  = (state_q == StRun);
    assign cnt_clr = abort || (state_q != StRun);

    dwell_cnt #(
        .DWELL(DWELL)
    ) u_dwell_cnt (
        .clk(clk),
        .rst(rst),
        .clr(cnt_clr),
        .en (cnt_en),
        .tc (cnt_tc)
    );

    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        dout_d  = dout_q;
        cont_d  = cont_q;

        if (abort) begin
            state_d = StIdle;
            sel_d   = SEL0;
            dout_d  = '0;
            cont_d  = 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (start) begin
                        state_d = StRun;
                        sel_d   = SEL0;
                        dout_d  = din;
                        cont_d  = cont;
                    end
                end
                StRun: begin
                    if (cnt_tc) begin
                        if (sel_q != SEL3) begin
                            sel_d = sel_q + 2'd1;
                        end else if (cont_q) begin
                            sel_d = SEL0;
                        end else begin
                            state_d = StDone;
                        end
                    end
                end
                StDone: begin
                    state_d = StIdle;
                    sel_d   = SEL0;
                    dout_d  = '0;
                end
                default: begin
                    state_d = StIdle;
                    sel_d   = SEL0;
                    dout_d  = '0;
                end
            endcase
        end

        busy_d = (state_d == StRun);
        done_d = (state_d == StDone);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            sel_q   <= SEL0;
            dout_q  <= '0;
            cont_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            dout_q  <= dout_d;
            cont_q  <= cont_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign sel  = sel_q;
    assign dout = dout_q;
    assign busy = busy_q;
    assign done = done_q;

endmodule

// File: doc/demux_sel_seq.md
DEMUX_SEL_SEQ -- requirements
Module: demux_sel_seq

Interface
REQ-001 Parameter DWELL, default 100, SHALL set the number of clock cycles each select code is held; legal range 1..65535.
REQ-002 Parameter DW, default 1, SHALL set the data width driven toward the downstream 1-to-4 demux.
REQ-003 Port clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 Port rst  input  1  SHALL be the asynchronous, active-high reset.
REQ-005 Port start  input  1  SHALL request one sweep and is sampled only in IDLE.
REQ-006 Port cont  input  1  SHALL, sampled with start, select continuous wrap-around sweeping (1) or a single sweep (0).
REQ-007 Port abort  input  1  SHALL terminate any sweep.
REQ-008 Port din  input  DW  SHALL be the data value to route, captured at start.
REQ-009 Port dout  output  DW  SHALL be the registered data toward the demux input.
REQ-010 Port sel  output  2  SHALL be the registered demux select code.
REQ-011 Port busy  output  1  SHALL be high while in RUN.
REQ-012 Port done  output  1  SHALL pulse high for one cycle when a single sweep completes.

Function
REQ-013 The FSM SHALL have exactly three states: IDLE, RUN, DONE.
REQ-014 In IDLE with start=1, the next cycle SHALL enter RUN with sel=00, dout=din (as sampled), the cont value latched, dwell counter=0 and busy=1.
REQ-015 In RUN the dwell counter SHALL increment every cycle; when it reaches DWELL-1 it SHALL clear and sel SHALL advance by one, so each code is held exactly DWELL cycles.
REQ-016 When sel=11 completes its dwell and latched cont=1, sel SHALL wrap to 00 with no gap cycle and RUN SHALL continue.
REQ-017 When sel=11 completes its dwell and latched cont=0, the FSM SHALL enter DONE; sel SHALL hold 11, dout SHALL hold its value, and busy SHALL fall in the same cycle.
REQ-018 DONE SHALL last exactly one cycle with done=1, then return to IDLE with sel=00 and dout=0.
REQ-019 start SHALL be ignored in RUN and DONE, and din SHALL NOT be re-sampled during a sweep.
REQ-020 abort=1 in any state SHALL force IDLE on the next edge with sel=00, dout=0, busy=0, done=0; abort takes priority over start and over dwell expiry in the same cycle.
REQ-021 With DWELL=1, sel SHALL change every cycle (00,01,10,11), giving a single-sweep latency from start to done of exactly 5 cycles.
REQ-022 Single-sweep latency SHALL be 4*DWELL+1 cycles from the start-sampling edge to the done pulse.
REQ-023 The dwell counter SHALL be 16 bits wide, unsigned, and SHALL never exceed DWELL-1.

Reset
REQ-024 While rst=1, state SHALL be IDLE, sel=00, dout=0, busy=0, done=0, counter=0 and latched cont=0, independently of clk.
REQ-025 Reset asserted mid-sweep SHALL abandon the sweep with no done pulse; after release, the block SHALL wait for a new start.

Structure
REQ-026 A shared package SHALL hold the state encoding (IDLE=2'd0, RUN=2'd1, DONE=2'd2) and the select constants SEL0..SEL3 (2'b00..2'b11), and the downstream demux SHALL use the same package.
REQ-027 The dwell counter SHALL be a sub-module, dwell_cnt (inputs clr and en, parameter DWELL, output tc).
REQ-028 The implementation SHALL target 120-400 lines in total.

Verification
REQ-029 DWELL=100, din=1, cont=0, start for one cycle -> sel=00,01,10,11, each for 100 cycles; done high at cycle 401 only; then sel=00, dout=0.
REQ-030 DWELL=3, cont=1 -> sel sequence 00,01,10,11,00,... repeats for at least 3 laps with no done and busy held at 1.
REQ-031 DWELL=5, abort asserted while sel=10 -> next cycle IDLE, sel=00, busy=0, no done pulse; a later start begins cleanly at 00.
REQ-032 DWELL=1 -> done exactly 5 cycles after start; start pulses during RUN are ignored.
REQ-033 rst asserted asynchronously mid-RUN (between edges) -> outputs reach reset values immediately; same-cycle start+abort in IDLE -> block stays in IDLE.
REQ-034 din toggled during RUN -> dout unchanged for the whole sweep.
